// File: rtl/sumador_pipe_if.sv
// sumador_pipe_if: operation/result bundle for the pipelined add/subtract unit.
//
// Signals (names follow the unit's datasheet):
//   ENB        pipeline enable; 0 freezes every internal register
//   IN_VALID   an operation is present on A/B/Cin/MODO
//   A, B       operands, WIDTH bits
//   Cin        carry-in (add) or borrow-in (subtract)
//   MODO       00 hold, 01 add, 10 subtract, 11 clear
//   Q          result, WIDTH bits
//   RCO        carry-out (add) or borrow-out (subtract)
//   OVF        two's-complement overflow
//   ZERO       Q == 0 for the emitted result
//   OUT_VALID  one-cycle qualifier for Q/RCO/OVF/ZERO
//
// Handshake: valid-only, no ready. An operation is taken on every rising
// clock edge that sees ENB=1 and IN_VALID=1; the unit never pushes back.
// OUT_VALID is high for exactly one cycle per emitted result.
//
// Modports: master drives operations and observes results (the bench or
// an upstream datapath); slave is the arithmetic unit.
interface sumador_pipe_if #(
  parameter int WIDTH = 32
);
  logic             ENB;
  logic             IN_VALID;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             OVF;
  logic             ZERO;
  logic             OUT_VALID;

  modport master (
    output ENB, IN_VALID, A, B, Cin, MODO,
    input  Q, RCO, OVF, ZERO, OUT_VALID
  );

  modport slave (
    input  ENB, IN_VALID, A, B, Cin, MODO,
    output Q, RCO, OVF, ZERO, OUT_VALID
  );
endinterface

// File: rtl/sumador_pipe.sv
// sumador_pipe: pipelined add/subtract unit with a carry that ripples
// through registered SLICE-bit stages, one new operation per enabled cycle.
//
// Ports:
//   CLK   rising-edge clock
//   RST   asynchronous, active-high reset
//   bus   sumador_pipe_if.slave (ENB, IN_VALID, A, B, Cin, MODO in;
//         Q, RCO, OVF, ZERO, OUT_VALID out)
//
// Latency: accepted at enabled edge n, emitted at enabled edge n+STAGES.
// Stage k holds the operand bits not yet consumed, shifted down so the
// next slice to add always sits in bits [SLICE-1:0]; computed result slices
// shift in from the top. After STAGES shifts the whole result is aligned,
// which gives both the operand skew and the result deskew for free.
module sumador_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic          CLK,
  input  logic          RST,
  sumador_pipe_if.slave bus
);

  localparam int STAGES = (WIDTH / SLICE < 1) ? 1 : WIDTH / SLICE;

  typedef enum logic [1:0] {
    MODO_HOLD = 2'b00,
    MODO_ADD  = 2'b01,
    MODO_SUB  = 2'b10,
    MODO_CLR  = 2'b11
  } modo_e;

  typedef struct packed {
    logic             vld;
    modo_e            mode;
    logic             cy;     // carry into the next slice to be added
    logic             a_msb;  // original operand sign bits, for OVF
    logic             b_msb;
    logic [WIDTH-1:0] a_rem;  // unconsumed A bits, next slice at the bottom
    logic [WIDTH-1:0] b_rem;  // unconsumed B bits (already inverted for sub)
    logic [WIDTH-1:0] res;    // finished result slices, filling from the top
  } stage_t;

  // One ripple step: add the bottom slice, shift operands down, shift the
  // new result slice in at the top.
  function automatic stage_t step(input stage_t s);
    stage_t         r;
    logic [SLICE:0] sum;
    sum     = {1'b0, s.a_rem[SLICE-1:0]} + {1'b0, s.b_rem[SLICE-1:0]}
            + (SLICE + 1)'(s.cy);
    r       = s;
    r.cy    = sum[SLICE];
    r.a_rem = s.a_rem >> SLICE;
    r.b_rem = s.b_rem >> SLICE;
    r.res   = (s.res >> SLICE) | (WIDTH'(sum[SLICE-1:0]) << (WIDTH - SLICE));
    return r;
  endfunction

  stage_t           st_q [STAGES];
  stage_t           st_d [STAGES];
  stage_t           entry;
  stage_t           fin;
  logic             is_sub;
  logic             emit;
  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  // Pipeline next-state. Subtract is A + ~B + ~Cin, so the inversion is
  // applied once on entry and every stage is a plain adder.
  always_comb begin
    is_sub      = (bus.MODO == MODO_SUB);
    entry       = '0;
    entry.vld   = bus.IN_VALID;
    entry.mode  = modo_e'(bus.MODO);
    entry.cy    = is_sub ? ~bus.Cin : bus.Cin;
    entry.a_msb = bus.A[WIDTH-1];
    entry.b_msb = bus.B[WIDTH-1];
    entry.a_rem = bus.A;
    entry.b_rem = is_sub ? ~bus.B : bus.B;

    st_d[0] = bus.ENB ? step(entry) : st_q[0];
    for (int k = 1; k < STAGES; k++) begin
      st_d[k] = bus.ENB ? step(st_q[k-1]) : st_q[k];
    end
  end

  // Output stage. Results only move on an enabled edge that emits a
  // non-hold operation; OUT_VALID drops on every other edge, including
  // stalled ones, so each result is flagged once.
  always_comb begin
    fin         = st_q[STAGES-1];
    emit        = bus.ENB && fin.vld && (fin.mode != MODO_HOLD);
    q_d         = q_q;
    rco_d       = rco_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = emit;
    if (emit) begin
      if (fin.mode == MODO_CLR) begin
        q_d    = '0;
        rco_d  = 1'b0;
        ovf_d  = 1'b0;
        zero_d = 1'b1;
      end else begin
        q_d    = fin.res;
        // Borrow is the inverse of the final carry when subtracting.
        rco_d  = (fin.mode == MODO_SUB) ? ~fin.cy : fin.cy;
        if (fin.mode == MODO_ADD) begin
          ovf_d = (fin.a_msb == fin.b_msb) && (fin.res[WIDTH-1] != fin.a_msb);
        end else begin
          ovf_d = (fin.a_msb != fin.b_msb) && (fin.res[WIDTH-1] != fin.a_msb);
        end
        zero_d = (fin.res == '0);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
      q_q         <= '0;
      rco_q       <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
      q_q         <= q_d;
      rco_q       <= rco_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.Q         = q_q;
  assign bus.RCO       = rco_q;
  assign bus.OVF       = ovf_q;
  assign bus.ZERO      = zero_q;
  assign bus.OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_sumador_pipe.sv
// tb_sumador_pipe: directed bench for sumador_pipe. A 32/8 instance is
// checked every cycle against an arithmetic model with a delay queue, plus
// literal expectations at known emission points; an 8/8 instance covers
// the single-stage configuration.
module tb_sumador_pipe;

  localparam int STG = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  sumador_pipe_if #(.WIDTH(32)) bus32 ();
  sumador_pipe_if #(.WIDTH(8))  bus8 ();

  sumador_pipe #(.WIDTH(32), .SLICE(8)) dut32 (.CLK(clk), .RST(rst), .bus(bus32));
  sumador_pipe #(.WIDTH(8),  .SLICE(8)) dut8  (.CLK(clk), .RST(rst), .bus(bus8));

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] q, input logic rco,
                     input logic ovf, input logic zero, input logic ov);
    chk({name, ".q"},    bus32.Q,                q);
    chk({name, ".rco"},  32'(bus32.RCO),         32'(rco));
    chk({name, ".ovf"},  32'(bus32.OVF),         32'(ovf));
    chk({name, ".zero"}, 32'(bus32.ZERO),        32'(zero));
    chk({name, ".ov"},   32'(bus32.OUT_VALID),   32'(ov));
  endtask

  task automatic lit8(input string name, input logic [7:0] q, input logic rco,
                      input logic ovf, input logic zero, input logic ov);
    chk({name, ".q"},    32'(bus8.Q),         32'(q));
    chk({name, ".rco"},  32'(bus8.RCO),       32'(rco));
    chk({name, ".ovf"},  32'(bus8.OVF),       32'(ovf));
    chk({name, ".zero"}, 32'(bus8.ZERO),      32'(zero));
    chk({name, ".ov"},   32'(bus8.OUT_VALID), 32'(ov));
  endtask

  // ---------------- arithmetic model ----------------
  // Plain integer arithmetic on w-bit operands; overflow is judged by
  // whether the true signed result fits in w bits.
  function automatic void model_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic [1:0] mode,
                                   output logic [31:0] q, output logic rco, output logic ovf);
    longint m, half, ua, ub, sa, sb, r, sr, c;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(a) & (m - 1);
    ub   = longint'(b) & (m - 1);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    c    = cin ? 1 : 0;
    q    = '0;
    rco  = 1'b0;
    ovf  = 1'b0;
    if (mode == 2'b01) begin
      r   = ua + ub + c;
      sr  = sa + sb + c;
      q   = 32'(r & (m - 1));
      rco = (r >= m);
      ovf = (sr >= half) || (sr < -half);
    end else if (mode == 2'b10) begin
      r   = ua - ub - c;
      sr  = sa - sb - c;
      q   = 32'((r + m) & (m - 1));
      rco = (r < 0);
      ovf = (sr >= half) || (sr < -half);
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        emit;
    logic [31:0] q;
    logic        rco;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] e_q    = '0;
  logic        e_rco  = 1'b0;
  logic        e_ovf  = 1'b0;
  logic        e_zero = 1'b0;
  logic        e_ov   = 1'b0;

  // Every enabled edge pushes one slot (bubbles included); the slot that
  // falls out STG edges later is what the unit emits.
  initial begin
    exp_t        r;
    logic [31:0] mq;
    logic        mr, mo;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        e_q = '0; e_rco = 1'b0; e_ovf = 1'b0; e_zero = 1'b0; e_ov = 1'b0;
      end else begin
        e_ov = 1'b0;
        if (bus32.ENB) begin
          model_op(32, bus32.A, bus32.B, bus32.Cin, bus32.MODO, mq, mr, mo);
          r.emit = bus32.IN_VALID && (bus32.MODO != 2'b00);
          r.q    = mq;
          r.rco  = mr;
          r.ovf  = mo;
          exp_q.push_back(r);
          if (exp_q.size() > STG) begin
            r = exp_q.pop_front();
            if (r.emit) begin
              e_q    = r.q;
              e_rco  = r.rco;
              e_ovf  = r.ovf;
              e_zero = (r.q == 0);
              e_ov   = 1'b1;
            end
          end
        end
      end
    end
  end

  // Cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc.ov",   32'(bus32.OUT_VALID), 32'(e_ov));
      chk("cyc.q",    bus32.Q,              e_q);
      chk("cyc.rco",  32'(bus32.RCO),       32'(e_rco));
      chk("cyc.ovf",  32'(bus32.OVF),       32'(e_ovf));
      chk("cyc.zero", 32'(bus32.ZERO),      32'(e_zero));
    end
  end

  // ---------------- drivers ----------------
  task automatic set32(input logic enb, input logic iv, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, input logic [1:0] mode);
    bus32.ENB = enb; bus32.IN_VALID = iv; bus32.A = a; bus32.B = b;
    bus32.Cin = cin; bus32.MODO = mode;
  endtask

  task automatic set8(input logic iv, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [1:0] mode);
    bus8.ENB = 1'b1; bus8.IN_VALID = iv; bus8.A = a; bus8.B = b;
    bus8.Cin = cin; bus8.MODO = mode;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                    input logic [1:0] mode);
    @(negedge clk);
    set32(1'b1, 1'b1, a, b, cin, mode);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      set32(1'b1, 1'b0, '0, '0, 1'b0, 2'b00);
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      set32(1'b0, 1'b0, '0, '0, 1'b0, 2'b00);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [1:0]  mode;
  } vec_t;

  vec_t vecs [10] = '{
    '{32'h0000_0000, 32'h0000_0000, 1'b0, 2'b01},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b01},
    '{32'h0000_0000, 32'h0000_0001, 1'b0, 2'b10},
    '{32'h0000_0000, 32'h0000_0000, 1'b1, 2'b10},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 2'b01},
    '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 2'b01},
    '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2'b10},
    '{32'h0000_0000, 32'h0000_0000, 1'b0, 2'b11},
    '{32'hAAAA_5555, 32'h5555_AAAA, 1'b0, 2'b00},
    '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b10}
  };

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] mq;
    logic        mr, mo;
    int          pulses;

    rst = 1'b1;
    set32(1'b0, 1'b0, '0, '0, 1'b0, 2'b00);
    set8(1'b0, '0, '0, 1'b0, 2'b00);

    // Pin the model against hand-computed results.
    model_op(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 2'b01, mq, mr, mo);
    chk("model.ripple.q", mq, 32'h0); chk("model.ripple.rco", 32'(mr), 32'd1);
    model_op(32, 32'd5, 32'd7, 1'b1, 2'b10, mq, mr, mo);
    chk("model.borrow.q", mq, 32'hFFFF_FFFD); chk("model.borrow.rco", 32'(mr), 32'd1);
    model_op(32, 32'h7FFF_FFFF, 32'h1, 1'b0, 2'b01, mq, mr, mo);
    chk("model.ovfadd.q", mq, 32'h8000_0000); chk("model.ovfadd.ovf", 32'(mo), 32'd1);
    model_op(32, 32'h8000_0000, 32'h1, 1'b0, 2'b10, mq, mr, mo);
    chk("model.ovfsub.q", mq, 32'h7FFF_FFFF); chk("model.ovfsub.ovf", 32'(mo), 32'd1);
    model_op(8, 32'hF0, 32'h20, 1'b0, 2'b01, mq, mr, mo);
    chk("model.w8.q", mq, 32'h10); chk("model.w8.rco", 32'(mr), 32'd1);

    repeat (2) @(negedge clk);
    lit("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit8("reset8", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Carry ripple across all slices, accepted on the first edge after release.
    @(negedge clk);
    rst = 1'b0;
    set32(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 2'b01);
    idle(STG);
    lit("ripple.before", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    lit("ripple", 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
    lit("ripple.after", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    op(32'd5, 32'd7, 1'b1, 2'b10);
    idle(STG + 1);
    lit("borrow", 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 1'b1);

    op(32'h7FFF_FFFF, 32'h1, 1'b0, 2'b01);
    idle(STG + 1);
    lit("ovf_add", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

    op(32'h8000_0000, 32'h1, 1'b0, 2'b10);
    idle(STG + 1);
    lit("ovf_sub", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);

    // Mixed modes back-to-back: add, hold, clear, sub.
    op(32'd1, 32'd2, 1'b0, 2'b01);
    op(32'hDEAD, 32'hBEEF, 1'b1, 2'b00);
    op(32'hDEAD, 32'hBEEF, 1'b1, 2'b11);
    op(32'd9, 32'd4, 1'b0, 2'b10);
    idle(2);
    lit("mix.add", 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    lit("mix.hold", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    lit("mix.clear", 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    lit("mix.sub", 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);

    // Stall for 3 cycles with 4 operations in flight.
    op(32'd10, 32'd20, 1'b0, 2'b01);
    op(32'd100, 32'd1, 1'b0, 2'b10);
    op(32'd7, 32'd8, 1'b0, 2'b01);
    op(32'd3, 32'd3, 1'b1, 2'b11);
    stall(3);
    idle(1);
    lit("stall.quiet", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    lit("stall.r0", 32'd30, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    lit("stall.r1", 32'd99, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    lit("stall.r2", 32'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    lit("stall.r3", 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    lit("stall.done", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges with operations in flight.
    op(32'd1, 32'd1, 1'b0, 2'b01);
    idle(STG + 1);
    lit("pre_rst", 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    op(32'd4, 32'd4, 1'b0, 2'b01);
    op(32'd5, 32'd5, 1'b0, 2'b01);
    op(32'd6, 32'd6, 1'b0, 2'b10);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    lit("rst_async", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (STG + 4) begin
      @(negedge clk);
      if (bus32.OUT_VALID) pulses++;
    end
    chk("rst.no_emit", 32'(pulses), 32'd0);
    lit("rst.after", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed table back-to-back, with a bubble and a stall mixed in;
    // checked by the cycle compare against the model.
    for (int i = 0; i < 10; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mode);
      if (i == 3) idle(1);
      if (i == 6) stall(2);
    end
    idle(STG + 3);

    // Single-stage configuration: result on the next enabled edge.
    @(negedge clk); set8(1'b1, 8'hF0, 8'h20, 1'b0, 2'b01);
    @(negedge clk); set8(1'b0, 8'h00, 8'h00, 1'b0, 2'b00);
    @(negedge clk);
    lit8("w8.add", 8'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    set8(1'b1, 8'h10, 8'h20, 1'b0, 2'b10);
    @(negedge clk); set8(1'b1, 8'h7F, 8'h01, 1'b0, 2'b01);
    lit8("w8.add.after", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); set8(1'b0, 8'h00, 8'h00, 1'b0, 2'b00);
    lit8("w8.sub", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    lit8("w8.ovf", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    lit8("w8.idle", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sumador_pipe.md
# sumador_pipe

Parametrised, pipelined add/subtract unit and successor to the fixed 4-bit nibble adder family. Operand width is configurable. The carry ripples through registered slices, so a new operation is accepted every cycle. Each output carries a valid qualifier plus signed-overflow and zero flags. It serves as the common arithmetic block for the 8/16/32-bit datapaths, replacing hand-chained nibble instances.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits computed per pipeline stage; STAGES = WIDTH/SLICE, minimum 1.
- CLK  in  1  rising-edge clock; single clock domain.
- RST  in  1  asynchronous, active-high reset.
- ENB  in  1  pipeline enable; 0 freezes all internal state.
- IN_VALID  in  1  operation present on A/B/Cin/MODO.
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand.
- Cin  in  1  carry-in (add) or borrow-in (subtract).
- MODO  in  2  operation: 00 hold, 01 add, 10 subtract, 11 clear.
- Q  out  WIDTH  result.
- RCO  out  1  carry-out (add) or borrow-out (subtract).
- OVF  out  1  two's-complement overflow.
- ZERO  out  1  Q == 0 for the emitted result.
- OUT_VALID  out  1  one-cycle qualifier for Q/RCO/OVF/ZERO.

## Operation
- Acceptance: an operation enters on a rising CLK edge with ENB=1 and IN_VALID=1. There is no backpressure; the unit always accepts.
- Stage k (0..STAGES-1) computes bits [k*SLICE +: SLICE] using the registered carry from stage k-1. Stage 0 uses Cin for add and ~Cin for subtract.
- Skew: upper operand slices are delayed so each reaches stage k with its carry. Lower result slices are deskewed so all of Q emits together.
- Add (01): {RCO,Q} = A + B + Cin, modulo 2^(WIDTH+1).
- Subtract (10): Q = (A - B - Cin) mod 2^WIDTH, computed as A + ~B + ~Cin. RCO = 1 when A < B + Cin (unsigned borrow), i.e. the inverted final carry.
- OVF:
  - Add: A[MSB]==B[MSB] and Q[MSB]!=A[MSB].
  - Subtract: A[MSB]!=B[MSB] and Q[MSB]!=A[MSB].
  - Otherwise 0.
- Clear (11): emits Q=0, RCO=0, OVF=0, ZERO=1 and OUT_VALID=1. A, B and Cin are ignored.
- Hold (00): the operation travels the pipeline as a bubble. At its emission edge Q/RCO/OVF/ZERO keep their previous values and OUT_VALID=0.
- Pipeline order is strictly in-order. Each operation's mode travels with it, so mixed modes back-to-back are legal.

## Timing
- Latency: an operation accepted at enabled edge n emits at enabled edge n+STAGES. With STAGES=1 it emits on the next enabled edge.
- Throughput: one operation per enabled cycle.
- OUT_VALID is registered. It is 1 only after an enabled edge that emits a non-hold operation, and is cleared on any edge without such an emission.
- ENB=0 at an edge:
  - All stage registers and valid bits hold.
  - Q/RCO/OVF/ZERO hold.
  - OUT_VALID is cleared, so every result is flagged exactly once.
  - Stalled cycles add exactly one cycle of latency each.
- IN_VALID=0 at an enabled edge inserts a bubble. It emits nothing, and outputs hold.
- Reset: while RST=1, with no clock required, Q=0, RCO=0, OVF=0, ZERO=0, OUT_VALID=0, and all stage valid bits and carries are 0.
- Reset mid-operation discards all in-flight operations; none emit after RST deasserts.
- First acceptance is possible at the first enabled edge after RST deasserts.
- Wrap-around: add and subtract wrap modulo 2^WIDTH. Wrap is reported only via RCO and OVF, never saturated.

## Test plan
All scenarios use WIDTH=32, SLICE=8 (latency 4) unless stated otherwise.
- Carry ripple across all slices: A=0xFFFF_FFFF, B=0x0000_0001, Cin=0, MODO=01 -> 4 edges later Q=0x0000_0000, RCO=1, ZERO=1, OVF=0, OUT_VALID pulses once.
- Borrow: A=5, B=7, Cin=1, MODO=10 -> Q=0xFFFF_FFFD, RCO=1, OVF=0, ZERO=0.
- Signed overflow, both directions:
  - A=0x7FFF_FFFF, B=1, MODO=01 -> Q=0x8000_0000, OVF=1, RCO=0.
  - A=0x8000_0000, B=1, MODO=10 -> Q=0x7FFF_FFFF, OVF=1, RCO=0.
- Back-to-back mixed modes on consecutive edges:
  - Issue add(1,2), hold, clear, sub(9,4).
  - Edges 4..7 show: Q=3 valid; Q=3 held with OUT_VALID=0; Q=0 with ZERO=1 valid; Q=5 valid.
- Stall and reset:
  - ENB=0 for 3 cycles with 4 operations in flight -> each result appears exactly 3 cycles later than unstalled, in order, with one OUT_VALID each.
  - Asserting RST asynchronously between edges with operations in flight -> all outputs 0 immediately, and no OUT_VALID after release.
- Degenerate configuration: WIDTH=8, SLICE=8, add 0xF0+0x20 -> Q=0x10, RCO=1 on the first enabled edge after acceptance.
